// File: rtl/kb_pkg.sv
// Shared PS/2 keyboard constants: scan codes (set 2 make codes) and control ASCII.
package kb_pkg;

  typedef logic [7:0] kb_code_t;

  localparam kb_code_t SC_0     = 8'h45;
  localparam kb_code_t SC_1     = 8'h16;
  localparam kb_code_t SC_2     = 8'h1E;
  localparam kb_code_t SC_3     = 8'h26;
  localparam kb_code_t SC_4     = 8'h25;
  localparam kb_code_t SC_5     = 8'h2E;
  localparam kb_code_t SC_6     = 8'h36;
  localparam kb_code_t SC_7     = 8'h3D;
  localparam kb_code_t SC_8     = 8'h3E;
  localparam kb_code_t SC_9     = 8'h46;
  localparam kb_code_t SC_A     = 8'h1C;
  localparam kb_code_t SC_B     = 8'h32;
  localparam kb_code_t SC_C     = 8'h21;
  localparam kb_code_t SC_D     = 8'h23;
  localparam kb_code_t SC_E     = 8'h24;
  localparam kb_code_t SC_F     = 8'h2B;
  localparam kb_code_t SC_ENTER = 8'h5A;
  localparam kb_code_t SC_BKSP  = 8'h66;
  localparam kb_code_t SC_SPACE = 8'h29;
  localparam kb_code_t SC_BRK   = 8'hF0;

  localparam kb_code_t ASC_CR   = 8'h0D;
  localparam kb_code_t ASC_BS   = 8'h08;
  localparam kb_code_t ASC_SP   = 8'h20;

endpackage

// File: rtl/kb_code_fifo_if.sv
// Code-tick / CPU-pop bus between the PS/2 filter, the code FIFO and the CPU port.
interface kb_code_fifo_if #(
  parameter int DEPTH_LOG2 = 3
);
  import kb_pkg::*;

  logic              code_tick;
  kb_code_t          code;
  logic              rd;
  kb_code_t          dout;
  logic              empty;
  logic              full;
  logic [DEPTH_LOG2:0] count;
  logic              ovf_tick;

  modport master (
    output code_tick, code, rd,
    input  dout, empty, full, count, ovf_tick
  );

  modport slave (
    input  code_tick, code, rd,
    output dout, empty, full, count, ovf_tick
  );
endinterface

// File: rtl/kb_scan_xlate.sv
// Combinational scan-code to ASCII map; hit=0 for codes with no mapping.
module kb_scan_xlate
  import kb_pkg::*;
(
  input  kb_code_t code,
  output kb_code_t ascii,
  output logic     hit
);

  always_comb begin
    ascii = '0;
    hit   = 1'b1;
    unique case (code)
      SC_0:     ascii = 8'h30;
      SC_1:     ascii = 8'h31;
      SC_2:     ascii = 8'h32;
      SC_3:     ascii = 8'h33;
      SC_4:     ascii = 8'h34;
      SC_5:     ascii = 8'h35;
      SC_6:     ascii = 8'h36;
      SC_7:     ascii = 8'h37;
      SC_8:     ascii = 8'h38;
      SC_9:     ascii = 8'h39;
      SC_A:     ascii = 8'h41;
      SC_B:     ascii = 8'h42;
      SC_C:     ascii = 8'h43;
      SC_D:     ascii = 8'h44;
      SC_E:     ascii = 8'h45;
      SC_F:     ascii = 8'h46;
      SC_ENTER: ascii = ASC_CR;
      SC_BKSP:  ascii = ASC_BS;
      SC_SPACE: ascii = ASC_SP;
      default:  hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/kb_code_fifo.sv
// First-word-fall-through queue of released-key codes for the CPU input port.
// Define KB_CODE_XLATE_EN to translate codes to ASCII and drop unmapped codes.
module kb_code_fifo
  import kb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input logic           clk,
  input logic           reset,
  kb_code_fifo_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  kb_code_t              mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wp_q, wp_d;
  logic [DEPTH_LOG2-1:0] rp_q, rp_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;

  kb_code_t wr_data;
  logic     wr_hit;
  logic     accept, push, pop, empty, full;

`ifdef KB_CODE_XLATE_EN
  kb_scan_xlate u_xlate (
    .code  (bus.code),
    .ascii (wr_data),
    .hit   (wr_hit)
  );
`else
  assign wr_data = bus.code;
  assign wr_hit  = 1'b1;
`endif

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  // When full, a simultaneous pop frees the slot being written (wp == rp).
  always_comb begin
    accept  = bus.code_tick && wr_hit;
    pop     = bus.rd && !empty;
    push    = accept && (!full || bus.rd);
    ovf_d   = accept && full && !bus.rd;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (push) wp_d = wp_q + PTR_ONE;
    if (pop)  rp_d = rp_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wp_q] <= wr_data;
  end

  assign bus.dout     = empty ? '0 : mem_q[rp_q];
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.ovf_tick = ovf_q;

endmodule

// File: tb/tb_kb_code_fifo.sv
// Directed bench for kb_code_fifo; expected codes follow KB_CODE_XLATE_EN if defined.
module tb_kb_code_fifo;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  kb_code_fifo_if #(.DEPTH_LOG2(3)) bus ();

  kb_code_fifo #(.DEPTH_LOG2(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xl(input logic [7:0] c);
`ifdef KB_CODE_XLATE_EN
    case (c)
      8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
      8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
      8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
      8'h46: return 8'h39;  8'h1C: return 8'h41;  8'h32: return 8'h42;
      8'h21: return 8'h43;  8'h23: return 8'h44;  8'h24: return 8'h45;
      8'h2B: return 8'h46;  8'h5A: return 8'h0D;  8'h66: return 8'h08;
      8'h29: return 8'h20;
      default: return 8'h00;
    endcase
`else
    return c;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, then observe registered state.
  task automatic step(input logic tk, input logic [7:0] c, input logic r);
    bus.code_tick = tk;
    bus.code      = c;
    bus.rd        = r;
    @(posedge clk);
    #1;
    bus.code_tick = 1'b0;
    bus.rd        = 1'b0;
  endtask

  task automatic drain_chk(input string tag, input logic [7:0] c);
    chk(tag, {24'h0, bus.dout}, {24'h0, xl(c)});
    step(1'b0, 8'h00, 1'b1);
  endtask

  logic [7:0] fill [8];

  initial begin
    fill = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
    bus.code_tick = 1'b0;
    bus.code      = 8'h00;
    bus.rd        = 1'b0;
    reset         = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full",  bus.full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_dout",  bus.dout, 0);
    chk("rst_ovf",   bus.ovf_tick, 0);

    // single code in, single pop out
    step(1'b1, 8'h16, 1'b0);
    chk("one_dout",  bus.dout, xl(8'h16));
    chk("one_empty", bus.empty, 0);
    chk("one_count", bus.count, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("pop_empty", bus.empty, 1);
    chk("pop_dout",  bus.dout, 0);

    // ordering across three codes
    step(1'b1, 8'h45, 1'b0);
    step(1'b1, 8'h1C, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    chk("ord_count", bus.count, 3);
    drain_chk("ord_0", 8'h45);
    drain_chk("ord_1", 8'h1C);
    drain_chk("ord_2", 8'h5A);
    chk("ord_empty", bus.empty, 1);

    // unmapped code
    step(1'b1, 8'h76, 1'b0);
`ifdef KB_CODE_XLATE_EN
    chk("unmap_count", bus.count, 0);
    chk("unmap_ovf",   bus.ovf_tick, 0);
`else
    chk("raw_count", bus.count, 1);
    chk("raw_dout",  bus.dout, 8'h76);
    step(1'b0, 8'h00, 1'b1);
`endif
    chk("unmap_empty", bus.empty, 1);

    // fill to full, overflow, then push+pop while full
    foreach (fill[i]) step(1'b1, fill[i], 1'b0);
    chk("fill_full",  bus.full, 1);
    chk("fill_count", bus.count, 8);
    step(1'b1, 8'h46, 1'b0);
    chk("ovf_tick",  bus.ovf_tick, 1);
    chk("ovf_count", bus.count, 8);
    chk("ovf_head",  bus.dout, xl(8'h16));
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_pulse", bus.ovf_tick, 0);
    step(1'b1, 8'h1C, 1'b1);
    chk("fpp_count", bus.count, 8);
    chk("fpp_ovf",   bus.ovf_tick, 0);
    chk("fpp_head",  bus.dout, xl(8'h1E));
    for (int i = 1; i < 8; i++) drain_chk("fpp_drain", fill[i]);
    drain_chk("fpp_tail", 8'h1C);
    chk("fpp_empty", bus.empty, 1);

    // push and pop on empty
    step(1'b1, 8'h26, 1'b1);
    chk("epp_count", bus.count, 1);
    chk("epp_dout",  bus.dout, xl(8'h26));
    step(1'b0, 8'h00, 1'b1);

    // reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b1, fill[i], 1'b0);
    chk("mid_count", bus.count, 5);
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    chk("mid_empty", bus.empty, 1);
    chk("mid_cnt0",  bus.count, 0);
    chk("mid_dout",  bus.dout, 0);
    step(1'b1, 8'h45, 1'b0);
    step(1'b1, 8'h32, 1'b0);
    drain_chk("mid_0", 8'h45);
    drain_chk("mid_1", 8'h32);
    chk("mid_end", bus.empty, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/kb_code_fifo.md
# kb_code_fifo

Buffers released-key scan codes from the PS/2 receive/break-code filter and presents them to the CPU input port as a first-word-fall-through queue. It sits directly downstream of the PS/2 code filter: it consumes that stage's one-cycle code tick and 8-bit code, optionally translates the code to ASCII, and holds it until the CPU pops it. This decouples keystroke arrival from CPU polling, so no key is lost while the CPU is busy.

## Interface
- DEPTH_LOG2, 3: log2 of FIFO depth (default 8 entries); legal 1..6.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- code_tick  in  1  one-cycle strobe: a released key's scan code is valid on code.
- code  in  8  scan code; sampled only when code_tick=1.
- rd  in  1  CPU pop request; ignored when empty=1.
- dout  out  8  head entry (ASCII or raw code); 8'h00 when empty.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- count  out  DEPTH_LOG2+1  number of stored entries.
- ovf_tick  out  1  one-cycle pulse: an accepted code was dropped because the FIFO was full.

## Operation
- Storage: register array of 2^DEPTH_LOG2 x 8; write pointer wp, read pointer rp (DEPTH_LOG2 bits, wrap modulo depth), count register (DEPTH_LOG2+1 bits).
- Accept condition: code_tick=1 and, when translation is compiled in, the code maps to a valid entry. Unmapped codes are silently discarded; they cause neither a write nor ovf_tick.
- Push: accepted and (not full, or rd=1 while full). The entry is written at wp, and wp increments.
- Pop: rd=1 and not empty. rp increments and the head advances.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with push and pop in the same cycle: both occur. Count stays at depth, and no ovf_tick is generated.
- Empty with push and pop in the same cycle: rd is ignored, the push occurs, and count becomes 1.
- Full with an accepted code and rd=0: the code is dropped, ovf_tick=1 for that cycle, and the stored contents are unchanged.
- dout = mem[rp] when not empty, else 8'h00. empty = (count==0). full = (count==depth).
- ovf_tick is registered from the drop condition.

## Timing
- Reset values: wp=0, rp=0, count=0, empty=1, full=0, dout=8'h00, ovf_tick=0. Memory contents are not reset.
- Reset mid-operation discards all queued codes within one cycle.
- A tick in cycle N gives entry visible on dout, empty=0 and count updated in cycle N+1.
- rd in cycle N gives the next entry (or empty=1) in cycle N+1.
- ovf_tick is asserted in cycle N+1 for a drop in cycle N.
- The upstream tick is at most one per PS/2 frame (≥ ~1000 clk cycles), but the block must handle a tick every cycle.

## Configuration
- KB_CODE_XLATE_EN defined: code is translated before storage, and unmapped codes are discarded. The mapping is:
  - 45,16,1E,26,25,2E,36,3D,3E,46 map to '0'..'9' (8'h30..8'h39).
  - 1C,32,21,23,24,2B map to 'A'..'F' (8'h41..8'h46).
  - 5A maps to 8'h0D, 66 maps to 8'h08, 29 maps to 8'h20.
- KB_CODE_XLATE_EN undefined: every ticked code is stored raw, and all codes are accepted.

## Structure
- Shared package kb_pkg holds:
  - the scan-code constants (SC_0..SC_9, SC_A..SC_F, SC_ENTER, SC_BKSP, SC_SPACE, SC_BRK=8'hF0);
  - the ASCII constants (ASC_CR, ASC_BS, ASC_SP).
- Sub-module kb_scan_xlate: purely combinational.
  - Input: code[7:0]. Outputs: ascii[7:0] and hit.
  - Instantiated only under KB_CODE_XLATE_EN. Without the macro, hit is tied to 1 and ascii to code.

## Test plan
- Reset, then tick code=8'h16 → next cycle dout=8'h31 (xlate) or 8'h16 (raw); empty=0; count=1. Then rd → next cycle empty=1, dout=8'h00.
- Tick codes 45,1C,5A on separate cycles, then three rds → dout sequence 8'h30, 8'h41, 8'h0D (xlate); FIFO empty afterward.
- Xlate build: tick code=8'h76 (unmapped) → count stays 0, no ovf_tick. Raw build: the same stimulus gives count=1, dout=8'h76.
- Fill 8 entries (full=1), tick a 9th with rd=0 → ovf_tick=1 for one cycle, count=8, head unchanged. Tick again with rd=1 → count=8, no ovf_tick, head advances, and the new code is stored at the tail.
- Empty FIFO, rd=1 and tick 8'h26 in the same cycle → count=1, dout=8'h33; rd has no effect.
- Load 5 entries, assert reset for one cycle mid-stream → empty=1, count=0, dout=8'h00. The next tick restarts at slot 0 with correct FIFO order.
